// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: valid/ready request in, one bus cycle at a
// time, valid/ready response out, with an optional bus timeout.
module wb_initiator #(
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_in,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [3:0]    req_be_i,
  input  logic [AW-1:0] req_adr_i,
  input  logic [31:0]   req_dat_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [31:0]   rsp_dat_o,
  output logic          rsp_err_o,
  output logic          cyc_o,
  output logic          stb_o,
  output logic          we_o,
  output logic [3:0]    be_o,
  output logic [AW-1:0] adr_o,
  output logic [31:0]   dat_o,
  input  logic          ack_i,
  input  logic          err_i,
  input  logic [31:0]   dat_i
);

  localparam int unsigned CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TimeoutEn = (TIMEOUT != 0);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StResp
  } state_e;

  state_e        r_state;
  logic          r_cyc;
  logic          r_we;
  logic [3:0]    r_be;
  logic [AW-1:0] r_adr;
  logic [31:0]   r_dat;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [31:0]   r_rsp_dat;
  logic [CW-1:0] r_cnt;

  logic w_expire;

  assign w_expire = TimeoutEn && (r_cnt == CntLast);

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= StIdle;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_dat   <= '0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (req_valid_i) begin
            r_cyc   <= 1'b1;
            r_we    <= req_we_i;
            r_be    <= req_be_i;
            r_adr   <= req_adr_i;
            r_dat   <= req_dat_i;
            r_state <= StBus;
          end
        end
        StBus: begin
          // Saturate at the expiry point so the counter can never wrap back to zero.
          if (TimeoutEn && (r_cnt != CntLast)) begin
            r_cnt <= r_cnt + CW'(1);
          end
          if (err_i) begin
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_dat   <= '0;
            r_state     <= StResp;
          end else if (ack_i) begin
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_dat   <= r_we ? '0 : dat_i;
            r_state     <= StResp;
          end else if (w_expire) begin
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_dat   <= '0;
            r_state     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_cnt       <= '0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Ready comes from state alone, so the requester never sees a comb path from its own valid.
  assign req_ready_o = (r_state == StIdle);
  assign cyc_o       = r_cyc;
  assign stb_o       = r_cyc;
  assign we_o        = r_we;
  assign be_o        = r_be;
  assign adr_o       = r_adr;
  assign dat_o       = r_dat;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_dat_o   = r_rsp_dat;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: RAM responder with registered ack, error/silent modes, and a
// word-level memory model that supplies every expected response.
module tb_wb_initiator;

  localparam int unsigned AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [3:0]    req_be = 4'h0;
  logic [AW-1:0] req_adr = '0;
  logic [31:0]   req_dat = '0;
  logic          rsp_ready = 1'b0;
  logic          req_ready, rsp_valid, rsp_err;
  logic [31:0]   rsp_dat;
  logic          cyc, stb, we, ack, err;
  logic [3:0]    be;
  logic [AW-1:0] adr;
  logic [31:0]   wdat, rdat_bus;

  logic          req_valid1 = 1'b0;
  logic          req_ready1, rsp_valid1, rsp_err1, cyc1, stb1, we1;
  logic [31:0]   rsp_dat1, dat1;
  logic [3:0]    be1;
  logic [AW-1:0] adr1;

  wb_initiator #(.AW(AW), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_in(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we), .req_be_i(req_be),
    .req_adr_i(req_adr), .req_dat_i(req_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .be_o(be), .adr_o(adr), .dat_o(wdat),
    .ack_i(ack), .err_i(err), .dat_i(rdat_bus)
  );

  wb_initiator #(.AW(AW), .TIMEOUT(0)) dut_nto (
    .clk_i(clk), .rst_in(rst_n),
    .req_valid_i(req_valid1), .req_ready_o(req_ready1), .req_we_i(1'b0), .req_be_i(4'hF),
    .req_adr_i('0), .req_dat_i(32'h0),
    .rsp_valid_o(rsp_valid1), .rsp_ready_i(1'b0), .rsp_dat_o(rsp_dat1), .rsp_err_o(rsp_err1),
    .cyc_o(cyc1), .stb_o(stb1), .we_o(we1), .be_o(be1), .adr_o(adr1), .dat_o(dat1),
    .ack_i(1'b0), .err_i(1'b0), .dat_i(32'h0)
  );

  // Responder: mode 0 = RAM with registered ack, 1 = err+ack on first cycle, 2 = silent.
  int          mode = 0;
  logic        ack_q;
  logic        ack_force = 1'b0;
  logic        err_force = 1'b0;
  logic [31:0] ram [64];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      for (int i = 0; i < 64; i++) ram[i] <= '0;
    end else begin
      ack_q <= (mode == 0) && cyc && stb && !ack_q;
      if ((mode == 0) && cyc && stb && !ack_q && we) begin
        for (int b = 0; b < 4; b++) if (be[b]) ram[adr[5:0]][8*b +: 8] <= wdat[8*b +: 8];
      end
    end
  end

  assign ack      = ack_q | ack_force | ((mode == 1) && cyc && stb);
  assign err      = err_force | ((mode == 1) && cyc && stb);
  assign rdat_bus = ram[adr[5:0]];

  logic [31:0] ref_mem [64];
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one request/response exchange; caller is positioned at a negedge.
  task automatic txn(input logic w, input logic [3:0] b, input logic [5:0] a,
                     input logic [31:0] d, input int hold,
                     output logic [31:0] o_dat, output logic o_err, output int o_cyc);
    int          n;
    logic        stable;
    logic [31:0] held_d;
    logic        held_e;
    req_valid = 1'b1; req_we = w; req_be = b; req_adr = 32'(a); req_dat = d;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("accept_wait", 32'(n < 50), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("cyc_latency", 32'(cyc), 32'd1);
    o_cyc = 0; stable = 1'b1; n = 0;
    while (!rsp_valid && n < 2000) begin
      if (cyc) begin
        o_cyc++;
        if (adr !== req_adr || we !== w || be !== b || wdat !== d || stb !== 1'b1) stable = 1'b0;
      end
      @(negedge clk); n++;
    end
    check("rsp_wait", 32'(n < 2000), 32'd1);
    check("wb_hold", 32'(stable), 32'd1);
    check("cyc_drop", 32'(cyc), 32'd0);
    held_d = rsp_dat; held_e = rsp_err; stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!rsp_valid || rsp_dat !== held_d || rsp_err !== held_e || cyc || req_ready) stable = 1'b0;
    end
    check("rsp_hold", 32'(stable), 32'd1);
    o_dat = rsp_dat; o_err = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_clear", 32'(rsp_valid), 32'd0);
  endtask

  // Expected response from the memory model: errors and writes return 0, reads the stored word.
  task automatic ref_txn(input logic w, input logic [3:0] b, input logic [5:0] a,
                         input logic [31:0] d, input int hold, output int o_cyc);
    logic [31:0] got_d, exp_d;
    logic        got_e, exp_e;
    txn(w, b, a, d, hold, got_d, got_e, o_cyc);
    exp_e = (mode != 0);
    exp_d = 32'h0;
    if (!exp_e) begin
      if (w) begin
        for (int i = 0; i < 4; i++) if (b[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
      end else begin
        exp_d = ref_mem[a];
      end
    end
    check("rsp_err", 32'(got_e), 32'(exp_e));
    check("rsp_dat", got_d, exp_d);
  endtask

  initial begin
    int          c;
    int          cnt;
    int          n;
    logic        stable;
    logic [31:0] d;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    #1 rst_n = 1'b0;
    #11;
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_be", 32'(be), 32'd0);
    check("rst_adr", adr, 32'd0);
    check("rst_dat", wdat, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_dat", rsp_dat, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read back, registered-ack responder.
    ref_txn(1'b1, 4'hF, 6'h10, 32'hA5A5_1234, 0, c);
    check("wr_cyc_len", 32'(c), 32'd2);
    ref_txn(1'b0, 4'hF, 6'h10, 32'h0, 1, c);
    check("rd_cyc_len", 32'(c), 32'd2);
    check("rd_ram", ram[16], 32'hA5A5_1234);

    // Partial write over an all-ones word.
    ref_txn(1'b1, 4'hF, 6'h20, 32'hFFFF_FFFF, 0, c);
    ref_txn(1'b1, 4'h1, 6'h20, 32'h0000_00AB, 0, c);
    ref_txn(1'b0, 4'hF, 6'h20, 32'h0, 0, c);
    check("partial_ram", ram[32], 32'hFFFF_FFAB);

    // Error with ack on the same cycle, then a normal request.
    mode = 1;
    ref_txn(1'b1, 4'hF, 6'h30, 32'hDEAD_BEEF, 2, c);
    check("err_cyc_len", 32'(c), 32'd1);
    mode = 0;
    ref_txn(1'b0, 4'hF, 6'h10, 32'h0, 0, c);

    // Timeout with a silent responder.
    mode = 2;
    ref_txn(1'b0, 4'hF, 6'h10, 32'h0, 0, c);
    check("timeout_cyc_len", 32'(c), 32'd8);
    mode = 0;

    // TIMEOUT = 0: bus cycle never ends.
    req_valid1 = 1'b1;
    @(negedge clk);
    req_valid1 = 1'b0;
    cnt = 0;
    repeat (1000) begin
      if (cyc1 && !rsp_valid1) cnt++;
      @(negedge clk);
    end
    check("nto_hold", 32'(cnt), 32'd1000);
    check("nto_ready", 32'(req_ready1), 32'd0);

    // Backpressure: response stalls while a new request waits.
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'hF; req_adr = 32'h20; req_dat = 32'h0;
    @(negedge clk);
    req_adr = 32'h10;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    check("bp_rsp_wait", 32'(n < 50), 32'd1);
    check("bp_rsp_dat", rsp_dat, ref_mem[32]);
    d = rsp_dat; stable = 1'b1;
    ack_force = 1'b1; err_force = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid || rsp_dat !== d || rsp_err !== 1'b0 || req_ready || cyc) stable = 1'b0;
    end
    ack_force = 1'b0; err_force = 1'b0;
    check("bp_stable", 32'(stable), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    cnt = 0;
    repeat (6) begin
      if (req_valid && req_ready) cnt++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("bp_accepts", 32'(cnt), 32'd1);
    check("bp_next_valid", 32'(rsp_valid), 32'd1);
    check("bp_next_dat", rsp_dat, ref_mem[16]);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Randomized traffic against the memory model.
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(0, 9);
      mode = (n == 0) ? 1 : (n == 1) ? 2 : 0;
      ref_txn(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 6'($urandom_range(0, 63)),
              $urandom, $urandom_range(0, 3), c);
    end

    // Reset in the middle of a bus cycle.
    mode = 2;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h5;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_cyc_up", 32'(cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cyc", 32'(cyc), 32'd0);
    check("mid_rst_stb", 32'(stb), 32'd0);
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    @(posedge clk);
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    @(negedge clk);
    check("stray_ack_cyc", 32'(cyc), 32'd0);
    check("stray_ack_valid", 32'(rsp_valid), 32'd0);
    check("stray_ack_err", 32'(rsp_err), 32'd0);
    check("stray_ack_dat", rsp_dat, 32'd0);
    check("stray_ack_ready", 32'(req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
- Single-outstanding Wishbone classic initiator.
- Converts a valid/ready request channel from a core or debug agent into one Wishbone cycle at a time, and returns the result on a valid/ready response channel.
- Drives 32-bit-data, byte-enabled word-addressed responders such as the SoC RAM wrappers.
- Includes a bus timeout so a missing responder cannot hang the requester.

Parameters:
- AW, 32, width of the word address driven on adr_o.
- TIMEOUT, 255, number of cycles cyc_o may stay high without ack_i/err_i before the initiator aborts; 0 disables the timeout.

Ports:
- clk_i  input  1  clock, rising edge
- rst_in  input  1  asynchronous, active-low reset
- req_valid_i  input  1  request present
- req_ready_o  output  1  request accepted when high together with req_valid_i
- req_we_i  input  1  1 = write, 0 = read
- req_be_i  input  4  byte enables
- req_adr_i  input  AW  word address
- req_dat_i  input  32  write data
- rsp_valid_o  output  1  response present
- rsp_ready_i  input  1  response consumed when high together with rsp_valid_o
- rsp_dat_o  output  32  read data; 0 for writes and errors
- rsp_err_o  output  1  bus error or timeout
- cyc_o, stb_o  output  1 each  Wishbone cycle/strobe
- we_o  output  1  Wishbone write enable
- be_o  output  4  Wishbone byte select
- adr_o  output  AW  Wishbone address
- dat_o  output  32  Wishbone write data
- ack_i  input  1  responder acknowledge
- err_i  input  1  responder error
- dat_i  input  32  responder read data

Behaviour:
- Reset (async, rst_in low):
  - State goes to IDLE.
  - cyc_o, stb_o, we_o, rsp_valid_o and rsp_err_o are 0; be_o, adr_o, dat_o and rsp_dat_o are 0; the timeout counter is 0.
  - Asserting reset mid-transaction drops cyc_o/stb_o immediately and discards any pending response.
- FSM states are IDLE, BUS and RESP.
- IDLE:
  - req_ready_o = 1; it is decoded purely from state, with no combinational path from req_valid_i.
  - On req_valid_i & req_ready_o, register we/be/adr/dat onto the Wishbone outputs, set cyc_o = stb_o = 1 and go to BUS.
  - Latency is 1 cycle from acceptance edge to cyc_o high.
- BUS:
  - req_ready_o = 0.
  - Wishbone outputs are held stable while cyc_o is high.
  - The timeout counter increments every cycle in BUS.
  - At each posedge, evaluate in priority order:
    - err_i = 1: drop cyc/stb, rsp_err_o = 1, rsp_dat_o = 0, go to RESP.
    - else ack_i = 1: drop cyc/stb, rsp_err_o = 0, rsp_dat_o = dat_i for reads or 0 for writes, go to RESP.
    - else, if TIMEOUT != 0 and the counter has reached TIMEOUT-1: drop cyc/stb, rsp_err_o = 1, rsp_dat_o = 0, go to RESP.
  - A simultaneous ack_i and err_i counts as an error.
  - An ack_i on the same edge as timeout expiry counts as a success.
  - cyc_o/stb_o are low for at least one cycle after every termination. This is required because toggling-ack responders must see the strobe drop before the next cycle.
- RESP:
  - rsp_valid_o = 1; rsp_dat_o and rsp_err_o are held stable until rsp_ready_i.
  - When rsp_ready_i is sampled high, clear rsp_valid_o, clear the counter and go to IDLE.
  - No new request is accepted in RESP, so back-to-back throughput is bounded by the response handshake.
- ack_i and err_i outside BUS are ignored and change no output.
- Minimum turnaround with a registered-ack responder:
  - cycle 0: accept
  - cycle 1: cyc_o high
  - cycle 2: ack_i high
  - cycle 3: rsp_valid_o high
  - cycle 4: earliest next acceptance, given rsp_ready_i = 1 in cycle 3.
- The counter is sized $clog2(TIMEOUT+1) and never wraps; it saturates at the timeout point.

Test Plan:
- Write, then read: write adr 0x10, data 0xA5A5_1234, be 0xF into the RAM model, then read adr 0x10.
  - Response 1: rsp_err = 0, rsp_dat = 0.
  - Response 2: rsp_dat = 0xA5A5_1234.
  - cyc_o is high for exactly 2 cycles per transaction and low at least 1 cycle between transactions.
- Partial write: preload 0xFFFF_FFFF, write 0x0000_00AB with be = 0x1, read back -> 0xFFFF_FFAB.
- Error: responder asserts err_i and ack_i together on the first bus cycle -> rsp_err = 1, rsp_dat = 0; the next request proceeds normally.
- Timeout: TIMEOUT = 8, no responder ack.
  - cyc_o falls exactly 8 cycles after rising and rsp_err = 1.
  - With TIMEOUT = 0, cyc_o stays high for 1000 cycles with no response.
- Backpressure: hold rsp_ready_i = 0 for 20 cycles while req_valid_i = 1.
  - rsp_valid_o and rsp_dat_o stay stable, req_ready_o = 0, cyc_o stays low.
  - Release -> exactly one new acceptance.
- Reset mid-cycle: pull rst_in low while cyc_o = 1 -> cyc_o/stb_o/rsp_valid_o drop with no clock edge; after release, req_ready_o = 1 on the first edge and a later ack_i is ignored.
